// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_pkg : shared state encoding and constants for the pipeline sequencer
// Revision 1.0
// ============================================================================
package pipeline_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [31:0] NOP_INST = 32'h0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_RUN      = 2'b01,
      ST_MEM_WAIT = 2'b10,
      ST_HALT     = 2'b11
   } state_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// load_use_detect : flags an ID instruction that reads the register a load in EX writes
// Revision 1.0
// ============================================================================
module load_use_detect
   import pipeline_pkg::*;
(
   input  logic                  id_ex_memread_i,
   input  logic [REG_ADDR_W-1:0] id_ex_rt_i,
   input  logic [REG_ADDR_W-1:0] if_id_rs_i,
   input  logic [REG_ADDR_W-1:0] if_id_rt_i,
   input  logic                  if_id_uses_rt_i,
   output logic                  load_use_o
);

   logic w_rs_match;
   logic w_rt_match;

   // $zero is never a real dependency
   assign w_rs_match = (id_ex_rt_i == if_id_rs_i);
   assign w_rt_match = if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i);
   assign load_use_o = id_ex_memread_i && (id_ex_rt_i != '0) && (w_rs_match || w_rt_match);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// pipeline_sequencer : stall/flush/freeze controller and run sequencing for the 5-stage pipeline
// Revision 1.0
// ============================================================================
module pipeline_sequencer
   import pipeline_pkg::*;
#(
   parameter int DMEM_TIMEOUT = 64,
   parameter int STALL_CNT_W  = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   start_i,
   input  logic                   id_ex_memread_i,
   input  logic [REG_ADDR_W-1:0]  id_ex_rt_i,
   input  logic [REG_ADDR_W-1:0]  if_id_rs_i,
   input  logic [REG_ADDR_W-1:0]  if_id_rt_i,
   input  logic                   if_id_uses_rt_i,
   input  logic                   branch_taken_i,
   input  logic                   jump_i,
   input  logic                   dmem_req_i,
   input  logic                   dmem_ready_i,
   output logic                   pc_write_o,
   output logic                   pc_sel_o,
   output logic                   if_id_write_o,
   output logic                   if_id_flush_o,
   output logic                   id_ex_write_o,
   output logic                   id_ex_bubble_o,
   output logic                   ex_mem_write_o,
   output logic                   mem_wb_write_o,
   output logic                   err_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o,
   output logic [1:0]             state_o
);

   localparam int                WAIT_W      = $clog2(DMEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(DMEM_TIMEOUT - 1);

   state_t                 r_state;
   state_t                 w_next_state;
   logic [WAIT_W-1:0]      r_wait_cnt;
   logic [STALL_CNT_W-1:0] r_stall_cnt;
   logic                   r_err;

   logic w_load_use;
   logic w_freeze;
   logic w_active;

   load_use_detect u_load_use_detect (
      .id_ex_memread_i (id_ex_memread_i),
      .id_ex_rt_i      (id_ex_rt_i),
      .if_id_rs_i      (if_id_rs_i),
      .if_id_rt_i      (if_id_rt_i),
      .if_id_uses_rt_i (if_id_uses_rt_i),
      .load_use_o      (w_load_use)
   );

   assign w_active = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);
   assign w_freeze = dmem_req_i && !dmem_ready_i;

   always_comb begin
      w_next_state   = r_state;
      pc_write_o     = 1'b0;
      pc_sel_o       = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_write_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      ex_mem_write_o = 1'b0;
      mem_wb_write_o = 1'b0;

      // A pending branch under a load-use stall is simply re-seen next cycle
      if (w_active && !w_freeze) begin
         id_ex_write_o  = 1'b1;
         ex_mem_write_o = 1'b1;
         mem_wb_write_o = 1'b1;
         if (w_load_use) begin
            id_ex_bubble_o = 1'b1;
         end else begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
            if (branch_taken_i || jump_i) begin
               pc_sel_o      = 1'b1;
               if_id_flush_o = 1'b1;
            end
         end
      end

      case (r_state)
         ST_IDLE: begin
            if (start_i) w_next_state = ST_RUN;
         end
         ST_RUN: begin
            if (w_freeze)      w_next_state = ST_MEM_WAIT;
            else if (!start_i) w_next_state = ST_IDLE;
         end
         ST_MEM_WAIT: begin
            if (dmem_ready_i)                   w_next_state = ST_RUN;
            else if (r_wait_cnt == c_wait_last) w_next_state = ST_HALT;
         end
         ST_HALT: begin
            w_next_state = ST_HALT;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= ST_IDLE;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_next_state;
         // Held at zero outside MEM_WAIT so every access starts counting from 0
         if (r_state == ST_MEM_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
         else                        r_wait_cnt <= '0;
         if (w_next_state == ST_HALT) r_err <= 1'b1;
         if (w_active && !pc_write_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   assign err_o       = r_err;
   assign stall_cnt_o = r_stall_cnt;
   assign state_o     = r_state;

endmodule : pipeline_sequencer
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pipeline_sequencer : directed self-checking bench for pipeline_sequencer
// Revision 1.0
// ============================================================================
module tb_pipeline_sequencer;

   localparam int TB_TIMEOUT = 8;
   localparam int TB_CNT_W   = 4;

   // Output vector order: pc_write, pc_sel, if_id_write, flush, id_ex_write, bubble, ex_mem, mem_wb
   localparam logic [7:0] c_off    = 8'h00;
   localparam logic [7:0] c_normal = 8'hAB;
   localparam logic [7:0] c_branch = 8'hFB;
   localparam logic [7:0] c_lu     = 8'h0F;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic id_ex_memread;
   logic [4:0] id_ex_rt;
   logic [4:0] if_id_rs;
   logic [4:0] if_id_rt;
   logic if_id_uses_rt;
   logic branch_taken;
   logic jump;
   logic dmem_req;
   logic dmem_ready;
   logic pc_write, pc_sel, if_id_write, if_id_flush;
   logic id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_write;
   logic err;
   logic [TB_CNT_W-1:0] stall_cnt;
   logic [1:0] state;
   logic [7:0] outs;

   int n_checks = 0;
   int n_fail   = 0;

   assign outs = {pc_write, pc_sel, if_id_write, if_id_flush,
                  id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_write};

   always #5 clk = ~clk;

   pipeline_sequencer #(
      .DMEM_TIMEOUT (TB_TIMEOUT),
      .STALL_CNT_W  (TB_CNT_W)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .start_i         (start),
      .id_ex_memread_i (id_ex_memread),
      .id_ex_rt_i      (id_ex_rt),
      .if_id_rs_i      (if_id_rs),
      .if_id_rt_i      (if_id_rt),
      .if_id_uses_rt_i (if_id_uses_rt),
      .branch_taken_i  (branch_taken),
      .jump_i          (jump),
      .dmem_req_i      (dmem_req),
      .dmem_ready_i    (dmem_ready),
      .pc_write_o      (pc_write),
      .pc_sel_o        (pc_sel),
      .if_id_write_o   (if_id_write),
      .if_id_flush_o   (if_id_flush),
      .id_ex_write_o   (id_ex_write),
      .id_ex_bubble_o  (id_ex_bubble),
      .ex_mem_write_o  (ex_mem_write),
      .mem_wb_write_o  (mem_wb_write),
      .err_o           (err),
      .stall_cnt_o     (stall_cnt),
      .state_o         (state)
   );

   task automatic clear_inputs();
      start = 0; id_ex_memread = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
      if_id_uses_rt = 0; branch_taken = 0; jump = 0; dmem_req = 0; dmem_ready = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   // Leaves the bench just after a negedge with the DUT in RUN and counters clear
   task automatic go_run();
      do_reset();
      start = 1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if (state !== 2'b00 || outs !== c_off || err !== 1'b0 || stall_cnt !== '0) begin
         $display("FAIL reset_state: state=%b outs=%h err=%b stall=%0d, need 00/00/0/0", state, outs, err, stall_cnt);
         n_fail++;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if (state !== 2'b00 || outs !== c_off) begin
            $display("FAIL idle_hold[%0d]: state=%b outs=%h, need 00/00", i, state, outs);
            n_fail++;
         end
      end
      @(negedge clk);
      start = 1; #1;
      n_checks++;
      if (state !== 2'b00 || outs !== c_off) begin
         $display("FAIL idle_start_same_cycle: state=%b outs=%h, need 00/00", state, outs);
         n_fail++;
      end
      @(negedge clk); #1;
      n_checks++;
      if (state !== 2'b01 || outs !== c_normal) begin
         $display("FAIL run_entry: state=%b outs=%h, need 01/ab", state, outs);
         n_fail++;
      end
   endtask

   task automatic test_load_use();
      go_run();
      id_ex_memread = 1; id_ex_rt = 2; if_id_rs = 2; if_id_rt = 4; if_id_uses_rt = 1; #1;
      n_checks++;
      if (outs !== c_lu) begin
         $display("FAIL lu_rs: outs=%h need %h", outs, c_lu);
         n_fail++;
      end
      @(negedge clk);
      id_ex_memread = 0; #1;
      n_checks++;
      if (outs !== c_normal || stall_cnt !== 4'd1) begin
         $display("FAIL lu_after: outs=%h stall=%0d need %h/1", outs, stall_cnt, c_normal);
         n_fail++;
      end
      id_ex_memread = 1; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0; #1;
      n_checks++;
      if (outs !== c_normal) begin
         $display("FAIL lu_zero_reg: outs=%h need %h", outs, c_normal);
         n_fail++;
      end
      id_ex_rt = 5; if_id_rs = 1; if_id_rt = 5; if_id_uses_rt = 1; #1;
      n_checks++;
      if (outs !== c_lu) begin
         $display("FAIL lu_rt: outs=%h need %h", outs, c_lu);
         n_fail++;
      end
      if_id_uses_rt = 0; #1;
      n_checks++;
      if (outs !== c_normal) begin
         $display("FAIL lu_rt_unused: outs=%h need %h", outs, c_normal);
         n_fail++;
      end
      id_ex_memread = 0;
   endtask

   task automatic test_branch();
      go_run();
      branch_taken = 1; #1;
      n_checks++;
      if (outs !== c_branch) begin
         $display("FAIL branch: outs=%h need %h", outs, c_branch);
         n_fail++;
      end
      @(negedge clk);
      branch_taken = 0; jump = 1; #1;
      n_checks++;
      if (outs !== c_branch) begin
         $display("FAIL jump: outs=%h need %h", outs, c_branch);
         n_fail++;
      end
      @(negedge clk);
      jump = 0; branch_taken = 1; id_ex_memread = 1; id_ex_rt = 3; if_id_rs = 3; #1;
      n_checks++;
      if (outs !== c_lu) begin
         $display("FAIL branch_lu_stall: outs=%h need %h", outs, c_lu);
         n_fail++;
      end
      @(negedge clk);
      id_ex_memread = 0; #1;
      n_checks++;
      if (outs !== c_branch) begin
         $display("FAIL branch_after_lu: outs=%h need %h", outs, c_branch);
         n_fail++;
      end
      @(negedge clk);
      branch_taken = 0; #1;
      n_checks++;
      if (outs !== c_normal || stall_cnt !== 4'd1) begin
         $display("FAIL branch_done: outs=%h stall=%0d need %h/1", outs, stall_cnt, c_normal);
         n_fail++;
      end
   endtask

   task automatic test_mem_wait();
      go_run();
      // freeze outranks a simultaneous load-use hazard
      dmem_req = 1; dmem_ready = 0; id_ex_memread = 1; id_ex_rt = 7; if_id_rs = 7; #1;
      n_checks++;
      if (state !== 2'b01 || outs !== c_off) begin
         $display("FAIL mem_c1: state=%b outs=%h need 01/00", state, outs);
         n_fail++;
      end
      @(negedge clk);
      id_ex_memread = 0; #1;
      n_checks++;
      if (state !== 2'b10 || outs !== c_off) begin
         $display("FAIL mem_c2: state=%b outs=%h need 10/00", state, outs);
         n_fail++;
      end
      @(negedge clk);
      dmem_ready = 1; #1;
      n_checks++;
      if (state !== 2'b10 || outs !== c_normal) begin
         $display("FAIL mem_c3_ready: state=%b outs=%h need 10/ab", state, outs);
         n_fail++;
      end
      @(negedge clk);
      dmem_req = 1; dmem_ready = 1; #1;
      n_checks++;
      if (state !== 2'b01 || stall_cnt !== 4'd2 || outs !== c_normal) begin
         $display("FAIL mem_back_run: state=%b stall=%0d outs=%h need 01/2/ab", state, stall_cnt, outs);
         n_fail++;
      end
      @(negedge clk);
      dmem_req = 0; dmem_ready = 0; #1;
      n_checks++;
      if (state !== 2'b01 || stall_cnt !== 4'd2) begin
         $display("FAIL zero_wait: state=%b stall=%0d need 01/2", state, stall_cnt);
         n_fail++;
      end
   endtask

   task automatic test_start_drop();
      go_run();
      dmem_req = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk); #1;
      n_checks++;
      if (state !== 2'b10) begin
         $display("FAIL start_drop_wait: state=%b need 10", state);
         n_fail++;
      end
      dmem_ready = 1;
      @(negedge clk);
      dmem_req = 0; dmem_ready = 0; #1;
      n_checks++;
      if (state !== 2'b01) begin
         $display("FAIL start_drop_run: state=%b need 01", state);
         n_fail++;
      end
      @(negedge clk); #1;
      n_checks++;
      if (state !== 2'b00 || outs !== c_off) begin
         $display("FAIL start_drop_idle: state=%b outs=%h need 00/00", state, outs);
         n_fail++;
      end
   endtask

   task automatic test_timeout();
      go_run();
      dmem_req = 1; dmem_ready = 0;
      for (int i = 0; i < TB_TIMEOUT; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if (state !== 2'b10 || err !== 1'b0) begin
            $display("FAIL timeout_wait[%0d]: state=%b err=%b need 10/0", i, state, err);
            n_fail++;
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1; dmem_ready = (i == 2); #1;
         n_checks++;
         if (state !== 2'b11 || err !== 1'b1 || outs !== c_off || stall_cnt !== 4'd9) begin
            $display("FAIL halt[%0d]: state=%b err=%b outs=%h stall=%0d need 11/1/00/9",
                     i, state, err, outs, stall_cnt);
            n_fail++;
         end
      end
      do_reset(); #1;
      n_checks++;
      if (state !== 2'b00 || err !== 1'b0 || stall_cnt !== '0) begin
         $display("FAIL halt_reset: state=%b err=%b stall=%0d need 00/0/0", state, err, stall_cnt);
         n_fail++;
      end
   endtask

   task automatic test_saturation();
      go_run();
      id_ex_memread = 1; id_ex_rt = 9; if_id_rs = 9;
      repeat (20) @(negedge clk);
      #1;
      n_checks++;
      if (stall_cnt !== 4'hF) begin
         $display("FAIL stall_saturate: stall=%0d need 15", stall_cnt);
         n_fail++;
      end
      id_ex_memread = 0;
   endtask

   task automatic test_async_reset();
      go_run();
      dmem_req = 1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (state !== 2'b10 || stall_cnt !== 4'd2) begin
         $display("FAIL areset_pre: state=%b stall=%0d need 10/2", state, stall_cnt);
         n_fail++;
      end
      #2 rst_n = 0;
      #1;
      n_checks++;
      if (state !== 2'b00 || stall_cnt !== '0 || err !== 1'b0 || outs !== c_off) begin
         $display("FAIL areset: state=%b stall=%0d err=%b outs=%h need 00/0/0/00", state, stall_cnt, err, outs);
         n_fail++;
      end
      clear_inputs();
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;
      clear_inputs();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_start_drop();
      test_timeout();
      test_saturation();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipeline_sequencer
`default_nettype wire
